// File: rtl/compare_stage.sv
// Registered compare unit with a two-entry skid buffer on the output side.
// in_ready and out_valid are flops, so out_ready never reaches in_ready combinationally.
module compare_stage #(
  parameter int width   = 32,
  parameter int rd_bits = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [width-1:0]   A,
  input  logic [width-1:0]   B,
  input  logic [rd_bits-1:0] rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   Out,
  output logic [rd_bits-1:0] out_rd
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t               state_q, state_d;
  logic                 main_res_q, main_res_d;
  logic [rd_bits-1:0]   main_rd_q, main_rd_d;
  logic                 skid_res_q, skid_res_d;
  logic [rd_bits-1:0]   skid_rd_q, skid_rd_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [width:0]       sum;
  logic [width-1:0]     diff;
  logic                 carry, ovf, eq, a_zero, a_neg, lt_u, lt_s, res;
  logic                 in_xfer, out_xfer;

  // Single adder A + ~B + 1 feeds SLTU (carry), SLT (sign ^ overflow) and EQ (zero diff).
  always_comb begin
    sum    = {1'b0, A} + {1'b0, ~B} + {{width{1'b0}}, 1'b1};
    diff   = sum[width-1:0];
    carry  = sum[width];
    ovf    = (A[width-1] ^ B[width-1]) & (diff[width-1] ^ A[width-1]);
    eq     = (diff == '0);
    lt_u   = ~carry;
    lt_s   = diff[width-1] ^ ovf;
    a_zero = (A == '0);
    a_neg  = A[width-1];
    case (op)
      3'd0:    res = lt_u;
      3'd1:    res = lt_s;
      3'd2:    res = eq;
      3'd3:    res = ~eq;
      3'd4:    res = a_neg | a_zero;
      3'd5:    res = ~a_neg & ~a_zero;
      3'd6:    res = a_neg;
      default: res = ~a_neg;
    endcase
  end

  always_comb begin
    in_xfer    = in_valid & in_ready_q;
    out_xfer   = out_valid_q & out_ready;
    state_d    = state_q;
    main_res_d = main_res_q;
    main_rd_d  = main_rd_q;
    skid_res_d = skid_res_q;
    skid_rd_d  = skid_rd_q;
    case (state_q)
      EMPTY: if (in_xfer) begin
        main_res_d = res;
        main_rd_d  = rd;
        state_d    = ONE;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_res_d = res;
          main_rd_d  = rd;
        end else if (in_xfer) begin
          skid_res_d = res;
          skid_rd_d  = rd;
          state_d    = FULL;
        end else if (out_xfer) begin
          state_d    = EMPTY;
        end
      end
      FULL: if (out_xfer) begin
        main_res_d = skid_res_q;
        main_rd_d  = skid_rd_q;
        state_d    = ONE;
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_res_q  <= 1'b0;
      main_rd_q   <= '0;
      skid_res_q  <= 1'b0;
      skid_rd_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_res_q  <= main_res_d;
      main_rd_q   <= main_rd_d;
      skid_res_q  <= skid_res_d;
      skid_rd_q   <= skid_rd_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Out       = {{(width-1){1'b0}}, main_res_q};
  assign out_rd    = main_rd_q;

endmodule

// File: tb/tb_compare_stage.sv
// Directed bench for compare_stage: opcode table, backpressure, streaming, mid-operation reset.
module tb_compare_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic [4:0]  rd;
  logic        out_valid, out_ready;
  logic [31:0] Out;
  logic [4:0]  out_rd;

  int checks = 0;
  int failures = 0;

  compare_stage #(.width(32), .rd_bits(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    in_valid = v; op = o; A = a; B = b; rd = r;
  endtask

  int seen;

  initial begin
    tbl[0]  = '{3'd0, 32'h1,        32'h2,        1'b1};
    tbl[1]  = '{3'd0, 32'hFFFFFFFF, 32'h1,        1'b0};
    tbl[2]  = '{3'd1, 32'hFFFFFFFF, 32'h1,        1'b1};
    tbl[3]  = '{3'd2, 32'h5,        32'h5,        1'b1};
    tbl[4]  = '{3'd1, 32'h80000000, 32'h7FFFFFFF, 1'b1};
    tbl[5]  = '{3'd0, 32'h80000000, 32'h7FFFFFFF, 1'b0};
    tbl[6]  = '{3'd4, 32'h0,        32'h12345678, 1'b1};
    tbl[7]  = '{3'd5, 32'h0,        32'h0,        1'b0};
    tbl[8]  = '{3'd6, 32'h80000000, 32'h0,        1'b1};
    tbl[9]  = '{3'd7, 32'h0,        32'hFFFFFFFF, 1'b1};
    tbl[10] = '{3'd1, 32'h80000000, 32'h1,        1'b1};
    tbl[11] = '{3'd0, 32'h7,        32'h7,        1'b0};
    tbl[12] = '{3'd3, 32'h3,        32'h4,        1'b1};
    tbl[13] = '{3'd2, 32'h3,        32'h4,        1'b0};
    tbl[14] = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 1'b0};
    tbl[15] = '{3'd5, 32'h1,        32'hFFFFFFFF, 1'b1};
    tbl[16] = '{3'd4, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[17] = '{3'd7, 32'h80000000, 32'h0,        1'b0};
    tbl[18] = '{3'd6, 32'h7FFFFFFF, 32'h0,        1'b0};
    tbl[19] = '{3'd3, 32'h9,        32'h9,        1'b0};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; A = '0; B = '0; rd = '0; out_ready = 1'b0;
    #12;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset Out",       Out,                32'd0);
    chk("reset out_rd",    {27'b0, out_rd},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Opcode table, streaming with out_ready=1: each result shows right after its accept edge.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 5'(i));
      step();
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d Out", i), Out, {31'b0, tbl[i].exp});
      chk($sformatf("vec%0d out_rd", i), {27'b0, out_rd}, 32'(i));
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    step();
    chk("drain out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: third request must wait while the buffer is full.
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 32'h1, 32'h1, 5'd1);
    step();
    chk("bp first in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp first out_rd",   {27'b0, out_rd},   32'd1);
    drive(1'b1, 3'd2, 32'h1, 32'h2, 5'd2);
    step();
    chk("bp full in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp hold out_rd",   {27'b0, out_rd},   32'd1);
    chk("bp hold Out",      Out,               32'd1);
    drive(1'b1, 3'd3, 32'h1, 32'h2, 5'd3);
    step();
    chk("bp stall out_rd", {27'b0, out_rd}, 32'd1);
    chk("bp stall valid",  {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    chk("bp rel1 out_rd", {27'b0, out_rd}, 32'd2);
    chk("bp rel1 Out",    Out,             32'd0);
    step();
    chk("bp rel2 out_rd", {27'b0, out_rd}, 32'd3);
    chk("bp rel2 Out",    Out,             32'd1);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    step();
    chk("bp empty valid", {31'b0, out_valid}, 32'd0);

    // Full throughput: 16 accepts, one result per cycle.
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'd0, 32'(i), 32'd8, 5'(i + 8));
      step();
      if (out_valid && out_rd == 5'(i + 8) && Out == {31'b0, (i < 8)}) seen++;
      chk($sformatf("stream%0d in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    step();
    chk("stream result count", 32'(seen), 32'd16);

    // Reset while FULL, asserted between edges.
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 32'h4, 32'h4, 5'd9);
    step();
    drive(1'b1, 3'd2, 32'h4, 32'h4, 5'd10);
    step();
    chk("pre-reset full", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("async rst in_ready",  {31'b0, in_ready},  32'd1);
    chk("async rst Out",       Out,                32'd0);
    chk("async rst out_rd",    {27'b0, out_rd},    32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-rst stale%0d", i), {31'b0, out_valid}, 32'd0);
    end
    drive(1'b1, 3'd6, 32'h80000000, 32'h0, 5'd17);
    step();
    chk("post-rst first valid", {31'b0, out_valid}, 32'd1);
    chk("post-rst first rd",    {27'b0, out_rd},    32'd17);
    chk("post-rst first Out",   Out,                32'd1);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/compare_stage.md
COMPARE_STAGE -- requirements
Module: compare_stage

Interface
REQ-001 Parameter: width, default 32, operand and result width.
REQ-002 Parameter: rd_bits, default 5, destination-register tag width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  upstream presents an operation.
REQ-006 Port: in_ready  output  1  stage can accept an operation this cycle.
REQ-007 Port: op  input  3  compare opcode (REQ-015).
REQ-008 Port: A  input  width  first operand.
REQ-009 Port: B  input  width  second operand.
REQ-010 Port: rd  input  rd_bits  destination tag, carried unchanged with the result.
REQ-011 Port: out_valid  output  1  result available downstream.
REQ-012 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-013 Port: Out  output  width  result; bit 0 = compare outcome, bits width-1:1 = 0.
REQ-014 Port: out_rd  output  rd_bits  tag of the result on Out.

Function
REQ-015 op decode: 0 SLTU (A<B unsigned); 1 SLT (A<B two's complement); 2 EQ (A==B); 3 NE (A!=B); 4 LEZ (A<=0 signed, B ignored); 5 GTZ (A>0 signed, B ignored); 6 LTZ (A<0 signed, B ignored); 7 GEZ (A>=0 signed, B ignored).
REQ-016 SLTU from the carry of A+~B+1: carry clear means A<B; A==B yields 0.
REQ-017 SLT from the width-bit difference: result = sign(diff) XOR overflow; A=0x80000000, B=0x00000001 yields 1.
REQ-018 Handshake: a transfer occurs on an edge where valid and ready are both 1; the payload (op, A, B, rd) is sampled only on an input transfer.
REQ-019 Latency: a result is registered and appears on Out/out_rd with out_valid=1 on the edge that accepts the input transfer; no combinational path from A/B/op to Out.
REQ-020 Buffering: two-entry skid buffer, a main register plus a skid register, so that in_ready is a register output and has no combinational dependence on out_ready.
REQ-021 Buffer states: EMPTY (out_valid=0, in_ready=1), ONE (out_valid=1, in_ready=1), FULL (out_valid=1, in_ready=0).
REQ-022 EMPTY -> ONE on an input transfer.
REQ-023 ONE -> EMPTY on an output transfer with no input transfer.
REQ-024 ONE stays ONE on simultaneous input and output transfers: the new result replaces the main register.
REQ-025 ONE -> FULL on an input transfer with no output transfer: the new result goes to the skid register.
REQ-026 FULL -> ONE on an output transfer: the skid entry moves to the main register.
REQ-027 FULL accepts no input.
REQ-028 Results leave in acceptance order; no loss and no duplication.
REQ-029 While out_valid=1 and out_ready=0, Out and out_rd hold stable.
REQ-030 in_valid while in_ready=0 has no effect; upstream holds its payload.

Reset
REQ-031 rst_n low forces EMPTY immediately, independent of clk: out_valid=0, in_ready=1, Out=0, out_rd=0, skid register cleared.
REQ-032 Entries in flight at reset assertion are discarded.
REQ-033 Release of rst_n takes effect on the next rising clk edge; the first transfer may occur on that edge.

Verification
REQ-034 Ordered compares, out_ready=1: SLTU A=1,B=2 -> Out=1; SLTU A=0xFFFFFFFF,B=1 -> Out=0; SLT A=0xFFFFFFFF,B=1 -> Out=1; EQ A=B=5 -> Out=1; each appears one cycle after acceptance.
REQ-035 Boundary operands: SLT A=0x80000000,B=0x7FFFFFFF -> Out=1; SLTU same operands -> Out=0; LEZ A=0 -> 1; GTZ A=0 -> 0; LTZ A=0x80000000 -> 1; GEZ A=0 -> 1.
REQ-036 Backpressure: out_ready=0, three back-to-back in_valid with rd=1,2,3 -> first two accepted and in_ready=0 after the second; release out_ready -> out_rd=1 then 2 then 3, in order and without loss.
REQ-037 Full throughput: in_valid=1 and out_ready=1 for 16 cycles -> 16 results, one per cycle, in_ready held at 1.
REQ-038 Reset mid-operation: FULL state, drop rst_n between clock edges -> out_valid=0, in_ready=1, Out=0 immediately; after release, no stale result appears.
